// File: rtl/bcd_to_bin.sv
// Five-digit packed BCD to 17-bit binary converter using sequential reverse double-dabble.
// One shift or one nibble-correction step per clock; out/err/done are registered.
module bcd_to_bin (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [19:0] in,
  output logic [16:0] out,
  output logic        done,
  output logic        busy,
  output logic        err
);

  localparam int unsigned BCD_W   = 20;
  localparam int unsigned BIN_W   = 17;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned NUM_DIG = 5;

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] SUB    = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]       state, state_d;
  logic [BCD_W-1:0] bcd, bcd_d;
  logic [BIN_W-1:0] bin, bin_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             invalid, invalid_d;
  logic [BIN_W-1:0] out_d;
  logic             err_d;
  logic             done_d;
  logic             busy_d;

  // True when any packed nibble holds a non-decimal code.
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(NUM_DIG); i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Undo the decimal carry: every nibble at 8 or above drops by 3, independently.
  function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < int'(NUM_DIG); i++) begin
      if (v[4*i +: 4] >= 4'd8) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state;
    bcd_d     = bcd;
    bin_d     = bin;
    cnt_d     = cnt;
    invalid_d = invalid;
    out_d     = out;
    err_d     = err;
    done_d    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          bcd_d     = in;
          bin_d     = '0;
          cnt_d     = '0;
          invalid_d = has_bad_digit(in);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {1'b0, bcd, bin[BIN_W-1:1]};
        cnt_d          = cnt + CNT_W'(1);
        state_d        = (cnt == LAST_SHIFT) ? FINISH : SUB;
      end
      SUB: begin
        bcd_d   = correct_digits(bcd);
        state_d = SHIFT;
      end
      FINISH: begin
        out_d   = invalid ? '0 : bin;
        err_d   = invalid;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // busy is registered from the next state so it tracks state != IDLE exactly.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bcd     <= '0;
      bin     <= '0;
      cnt     <= '0;
      invalid <= 1'b0;
      out     <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      bcd     <= bcd_d;
      bin     <= bin_d;
      cnt     <= cnt_d;
      invalid <= invalid_d;
      out     <= out_d;
      err     <= err_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed and swept checks for bcd_to_bin: latency, results, error flag, busy, reset abort.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [19:0] in = '0;
  logic [16:0] out;
  logic        done;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_to_bin dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in),
    .out   (out),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned n);
    logic [19:0] r;
    int unsigned x;
    x = n;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal-weighted reference: invalid digits force out=0, err=1.
  task automatic model(input logic [19:0] v, output logic [16:0] eo, output logic ee);
    int unsigned acc;
    logic [3:0] d;
    acc = 0;
    ee  = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      d = v[4*i +: 4];
      if (d > 4'd9) ee = 1'b1;
      acc = acc * 10 + int'(d);
    end
    eo = ee ? 17'd0 : 17'(acc);
  endtask

  // Present start at a falling edge; done is expected 35 falling edges later (load + 34).
  task automatic run_conv(input logic [19:0] v, input int inj_at, input logic [19:0] inj_v,
                          input string tag, input logic [16:0] exp_out, input logic exp_err);
    int   lat;
    logic busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    start   = 1'b1;
    in      = v;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        in    = ~v;
      end
      if (inj_at > 0 && i == inj_at) begin
        start = 1'b1;
        in    = inj_v;
      end
      if (inj_at > 0 && i == inj_at + 1) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, ":latency"}, 32'(lat), 32'd35);
    check({tag, ":out"}, 32'(out), 32'(exp_out));
    check({tag, ":err"}, 32'(err), 32'(exp_err));
    check({tag, ":busy"}, 32'(busy_ok), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({tag, ":done_width"}, 32'(done), 32'd0);
  endtask

  // Back-to-back conversions with start held high; in is changed at each done.
  task automatic sweep(input logic [19:0] vals[$]);
    int          lat;
    logic [16:0] eo;
    logic        ee;
    start = 1'b1;
    in    = vals[0];
    for (int k = 0; k < vals.size(); k++) begin
      model(vals[k], eo, ee);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (done) begin
          lat = i;
          break;
        end
      end
      check($sformatf("sweep_%05h:latency", vals[k]), 32'(lat), 32'd35);
      check($sformatf("sweep_%05h:out", vals[k]), 32'(out), 32'(eo));
      check($sformatf("sweep_%05h:err", vals[k]), 32'(err), 32'(ee));
      if (k + 1 < vals.size()) in = vals[k + 1];
      else start = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("sweep:idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] vals[$];
    logic        seen;

    // Reset state with the clock running.
    @(negedge clk);
    @(negedge clk);
    check("reset:out", 32'(out), 32'd0);
    check("reset:done", 32'(done), 32'd0);
    check("reset:busy", 32'(busy), 32'd0);
    check("reset:err", 32'(err), 32'd0);

    // Release and start in the same cycle: honoured at the first rising edge.
    reset = 1'b1;
    run_conv(20'h12345, 0, '0, "d12345", 17'h03039, 1'b0);
    run_conv(20'h99999, 0, '0, "d99999", 17'h1869F, 1'b0);
    run_conv(20'h00000, 0, '0, "d00000", 17'h00000, 1'b0);
    run_conv(20'h00001, 0, '0, "d00001", 17'h00001, 1'b0);
    run_conv(20'h80000, 0, '0, "d80000", 17'h13880, 1'b0);
    run_conv(20'h65536, 0, '0, "d65536", 17'h10000, 1'b0);
    run_conv(20'h1A345, 0, '0, "bad_tens", 17'h00000, 1'b1);
    run_conv(20'h00999, 0, '0, "d00999", 17'h003E7, 1'b0);
    run_conv(20'hF0000, 0, '0, "bad_top", 17'h00000, 1'b1);
    run_conv(20'h12345, 10, 20'h00777, "ignore_start", 17'h03039, 1'b0);

    // Abort at cycle 20 of a conversion with an asynchronous reset.
    start = 1'b1;
    in    = 20'h12345;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort:out", 32'(out), 32'd0);
    check("abort:busy", 32'(busy), 32'd0);
    check("abort:done", 32'(done), 32'd0);
    check("abort:err", 32'(err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort:no_restart", 32'(seen), 32'd0);
    run_conv(20'h05000, 0, '0, "d05000", 17'h01388, 1'b0);

    // Spread of valid values plus boundaries and a few invalid codes.
    for (int k = 0; k < 50; k++) vals.push_back(to_bcd(32'(k) * 2039 % 100000));
    vals.push_back(to_bcd(9));
    vals.push_back(to_bcd(10));
    vals.push_back(to_bcd(99));
    vals.push_back(to_bcd(100));
    vals.push_back(to_bcd(65535));
    vals.push_back(to_bcd(99998));
    vals.push_back(to_bcd(99999));
    vals.push_back(20'h9F999);
    vals.push_back(20'h0000C);
    vals.push_back(to_bcd(0));
    sweep(vals);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
